cv32e40p_obi_instr_responder: RTL and testbench

CV32E40P_OBI_INSTR_RESPONDER -- requirements
Module: cv32e40p_obi_instr_responder

---
 rtl/cv32e40p_obi_instr_responder.sv | 112 +++++++++++
 tb/tb_cv32e40p_obi_instr_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_instr_responder.sv
// OBI instruction-side responder backed by a one-cycle-latency SRAM.
// Grants are capped by DEPTH outstanding transactions. Responses are returned in grant order.
module cv32e40p_obi_instr_responder #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              obi_req_i,
  output logic              obi_gnt_o,
  input  logic [31:0]       obi_addr_i,
  output logic              obi_rvalid_o,
  output logic [31:0]       obi_rdata_o,
  output logic              obi_err_o,
  input  logic              gnt_stall_i,
  input  logic              resp_stall_i,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned   CW       = $clog2(DEPTH) + 1;
  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [32:0]   LIMIT    = {1'b0, BASE_ADDR} + (33'd4 << MEM_AW);

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   fifo_data [DEPTH];
  logic          fifo_err  [DEPTH];
  logic          pend_valid;
  logic          pend_err;

  logic          accept;
  logic          in_range;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [31:0]   pend_rdata;

  // The address is compared in 33 bits so that a window ending at 4 GiB cannot wrap.
  assign in_range   = ({1'b0, obi_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, obi_addr_i} < LIMIT);
  assign obi_gnt_o  = rst_n && obi_req_i && !gnt_stall_i && (out_cnt < DEPTH_C);
  assign accept     = obi_req_i && obi_gnt_o;
  assign mem_req_o  = accept && in_range;
  assign mem_addr_o = obi_addr_i[MEM_AW+1:2] - BASE_ADDR[MEM_AW+1:2];

  assign fifo_empty   = (fifo_cnt == '0);
  assign pend_rdata   = pend_err ? '0 : mem_rdata_i;
  assign obi_rvalid_o = rst_n && (!fifo_empty || pend_valid) && !resp_stall_i;
  assign pop          = obi_rvalid_o && !fifo_empty;
  // The pending word goes straight out only when the FIFO is empty and the response is not stalled.
  assign push         = pend_valid && !(obi_rvalid_o && fifo_empty);

  always_comb begin
    obi_rdata_o = '0;
    obi_err_o   = 1'b0;
    if (obi_rvalid_o) begin
      if (!fifo_empty) begin
        obi_rdata_o = fifo_data[rd_ptr];
        obi_err_o   = fifo_err[rd_ptr];
      end else begin
        obi_rdata_o = pend_rdata;
        obi_err_o   = pend_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt    <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_valid <= 1'b0;
      pend_err   <= 1'b0;
    end else begin
      pend_valid <= accept;
      pend_err   <= accept && !in_range;
      case ({accept, obi_rvalid_o})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= pend_rdata;
      fifo_err[wr_ptr]  <= pend_err;
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop) |-> (fifo_cnt != DEPTH_C));

  a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    obi_rvalid_o |-> (out_cnt != '0));

endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// Directed bench for cv32e40p_obi_instr_responder (DEPTH=2, MEM_AW=14, BASE_ADDR=0).
// The SRAM model returns 32'hC0DE_0000 + word address. On idle cycles it returns 32'hDEAD_BEEF.
module tb_cv32e40p_obi_instr_responder;

  localparam int unsigned MEM_AW = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              obi_req_i;
  logic              obi_gnt_o;
  logic [31:0]       obi_addr_i;
  logic              obi_rvalid_o;
  logic [31:0]       obi_rdata_o;
  logic              obi_err_o;
  logic              gnt_stall_i;
  logic              resp_stall_i;
  logic              mem_req_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_rdata_i = 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40p_obi_instr_responder #(
    .DEPTH     (2),
    .MEM_AW    (MEM_AW),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .gnt_stall_i  (gnt_stall_i),
    .resp_stall_i (resp_stall_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_rdata_i <= mem_req_o ? (32'hC0DE_0000 + 32'(mem_addr_o)) : 32'hDEAD_BEEF;

  function automatic logic [31:0] word(input int unsigned i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic gs, input logic rs);
    obi_req_i    = req;
    obi_addr_i   = addr;
    gnt_stall_i  = gs;
    resp_stall_i = rs;
    #1;
  endtask

  task automatic exp_gnt(input string tag, input logic g, input logic mr, input int unsigned ma);
    check({tag, ".gnt"}, 32'(obi_gnt_o), 32'(g));
    check({tag, ".mem_req"}, 32'(mem_req_o), 32'(mr));
    if (mr) check({tag, ".mem_addr"}, 32'(mem_addr_o), 32'(ma));
  endtask

  task automatic exp_rsp(input string tag, input logic rv, input logic [31:0] rd, input logic er);
    check({tag, ".rvalid"}, 32'(obi_rvalid_o), 32'(rv));
    check({tag, ".rdata"}, obi_rdata_o, rd);
    check({tag, ".err"}, 32'(obi_err_o), 32'(er));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();

    // Reset holds every output low even with a request pending.
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    exp_gnt("rst", 1'b0, 1'b0, 0);
    exp_rsp("rst", 1'b0, 32'h0, 1'b0);
    tick();

    // Back-to-back requests: the first grant lands in the first cycle after reset release.
    rst_n = 1'b1;
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    exp_gnt("b2b0", 1'b1, 1'b1, 0); exp_rsp("b2b0", 1'b0, 32'h0, 1'b0); tick();
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    exp_gnt("b2b1", 1'b1, 1'b1, 1); exp_rsp("b2b1", 1'b1, word(0), 1'b0); tick();
    drive(1'b1, 32'h8, 1'b0, 1'b0);
    exp_gnt("b2b2", 1'b1, 1'b1, 2); exp_rsp("b2b2", 1'b1, word(1), 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp_rsp("b2b3", 1'b1, word(2), 1'b0); tick();
    exp_rsp("b2b4", 1'b0, 32'h0, 1'b0); tick();

    // Response stall fills both slots; the grant reopens one cycle after the first response.
    drive(1'b1, 32'h10, 1'b0, 1'b1);
    exp_gnt("rs0", 1'b1, 1'b1, 4); exp_rsp("rs0", 1'b0, 32'h0, 1'b0); tick();
    drive(1'b1, 32'h14, 1'b0, 1'b1);
    exp_gnt("rs1", 1'b1, 1'b1, 5); exp_rsp("rs1", 1'b0, 32'h0, 1'b0); tick();
    drive(1'b1, 32'h18, 1'b0, 1'b1);
    exp_gnt("rs2", 1'b0, 1'b0, 0); exp_rsp("rs2", 1'b0, 32'h0, 1'b0); tick();
    drive(1'b1, 32'h18, 1'b0, 1'b1);
    exp_gnt("rs3", 1'b0, 1'b0, 0); exp_rsp("rs3", 1'b0, 32'h0, 1'b0); tick();
    drive(1'b1, 32'h18, 1'b0, 1'b0);
    exp_gnt("rs4", 1'b0, 1'b0, 0); exp_rsp("rs4", 1'b1, word(4), 1'b0); tick();
    drive(1'b1, 32'h18, 1'b0, 1'b0);
    exp_gnt("rs5", 1'b1, 1'b1, 6); exp_rsp("rs5", 1'b1, word(5), 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp_rsp("rs6", 1'b1, word(6), 1'b0); tick();
    exp_rsp("rs7", 1'b0, 32'h0, 1'b0); tick();

    // Window edge: the last word is in range, and the next byte address is an error.
    drive(1'b1, 32'h0000_FFFC, 1'b0, 1'b0);
    exp_gnt("oor0", 1'b1, 1'b1, 14'h3FFF); tick();
    drive(1'b1, 32'h0001_0000, 1'b0, 1'b0);
    exp_gnt("oor1", 1'b1, 1'b0, 0); exp_rsp("oor1", 1'b1, word(14'h3FFF), 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp_rsp("oor2", 1'b1, 32'h0, 1'b1); tick();
    exp_rsp("oor3", 1'b0, 32'h0, 1'b0); tick();

    // Streaming with simultaneous grant and response; the low address bits must be ignored.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(4 * i + (i % 4)), 1'b0, 1'b0);
      exp_gnt($sformatf("strm%0d", i), 1'b1, 1'b1, 32'(i));
      if (i > 0) exp_rsp($sformatf("strm%0d", i), 1'b1, word(32'(i - 1)), 1'b0);
      else       exp_rsp("strm0", 1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp_rsp("strm_end", 1'b1, word(19), 1'b0); tick();
    exp_rsp("strm_idle", 1'b0, 32'h0, 1'b0); tick();

    // A mid-operation reset drops both in-flight transactions.
    drive(1'b1, 32'h20, 1'b0, 1'b1);
    exp_gnt("mr0", 1'b1, 1'b1, 8); tick();
    drive(1'b1, 32'h24, 1'b0, 1'b1);
    exp_gnt("mr1", 1'b1, 1'b1, 9); tick();
    rst_n = 1'b0;
    drive(1'b1, 32'h28, 1'b0, 1'b0);
    exp_gnt("mr2", 1'b0, 1'b0, 0); exp_rsp("mr2", 1'b0, 32'h0, 1'b0); tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h30, 1'b0, 1'b0);
    exp_gnt("mr3", 1'b1, 1'b1, 12); exp_rsp("mr3", 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp_rsp("mr4", 1'b1, word(12), 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      exp_rsp($sformatf("mr_idle%0d", i), 1'b0, 32'h0, 1'b0);
      tick();
    end

    // Grant stall blocks acceptance, then the same request is taken normally.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40, 1'b1, 1'b0);
      exp_gnt($sformatf("gs%0d", i), 1'b0, 1'b0, 0);
      exp_rsp($sformatf("gs%0d", i), 1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    exp_gnt("gs3", 1'b1, 1'b1, 16); exp_rsp("gs3", 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp_rsp("gs4", 1'b1, word(16), 1'b0); tick();
    exp_rsp("gs5", 1'b0, 32'h0, 1'b0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
